// File: rtl/ft60x_pkg.sv
// Shared types for the FT60x 245-mode FIFO bridge.
// FSM states and bus-direction encoding.
package ft60x_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_OE,
    RD_BURST,
    RD_END,
    WR_BURST,
    WR_END
  } state_t;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with occupancy level.
// next_head exposes the word behind the head for zero-bubble streaming.
module sync_fifo_fwft #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic [WIDTH-1:0]      next_head,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_nxt;
  logic                  do_push;
  logic                  do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = level[ADDR_WIDTH];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_nxt  = rd_ptr[ADDR_WIDTH-1:0] + 1'b1;
  assign head    = mem[rd_ptr[ADDR_WIDTH-1:0]];

  // With one word stored, the follower is the word being written now.
  assign next_head = (level == ONE && do_push) ? push_data : mem[rd_nxt];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[ADDR_WIDTH-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ft60x_fifo_bridge.sv
// Synchronous 245-mode FT600/FT601 bridge with RX/TX FIFOs
// and burst-bounded fair arbitration of the half-duplex bus.
module ft60x_fifo_bridge
  import ft60x_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int BE_WIDTH     = DATA_WIDTH / 8,
  parameter int RX_BUF_WIDTH = 4,
  parameter int TX_BUF_WIDTH = 4,
  parameter int MAX_BURST    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   ft_data_i,
  output logic [DATA_WIDTH-1:0]   ft_data_o,
  output logic                    ft_data_oe,
  input  logic [BE_WIDTH-1:0]     ft_be_i,
  output logic [BE_WIDTH-1:0]     ft_be_o,
  input  logic                    ft_txe_n,
  input  logic                    ft_rxf_n,
  output logic                    ft_oe_n,
  output logic                    ft_rd_n,
  output logic                    ft_wr_n,
  input  logic [DATA_WIDTH-1:0]   tx_data,
  input  logic [BE_WIDTH-1:0]     tx_be,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [DATA_WIDTH-1:0]   rx_data,
  output logic [BE_WIDTH-1:0]     rx_be,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [RX_BUF_WIDTH:0]   rx_level,
  output logic [TX_BUF_WIDTH:0]   tx_level
);

  localparam int W        = DATA_WIDTH + BE_WIDTH;
  localparam int CW       = $clog2(MAX_BURST + 1);
  localparam int RX_DEPTH = 1 << RX_BUF_WIDTH;

  localparam logic [RX_BUF_WIDTH:0] RX_ALMOST =
    (RX_BUF_WIDTH+1)'(RX_DEPTH - 1);
  localparam logic [TX_BUF_WIDTH:0] TX_ONE =
    (TX_BUF_WIDTH+1)'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_CAP = CW'(MAX_BURST - 1);

  state_t        state;
  state_t        state_nx;
  dir_t          last_dir;
  dir_t          dir_nx;
  logic [CW-1:0] burst_cnt;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] cnt_inc;
  logic          cap;

  logic          rx_push;
  logic          rx_pop;
  logic          rx_full;
  logic          rx_empty;
  logic [W-1:0]  rx_head;
  logic [W-1:0]  unused_rx_next;

  logic          tx_push;
  logic          tx_pop;
  logic          tx_full;
  logic          tx_empty;
  logic [W-1:0]  tx_head;
  logic [W-1:0]  tx_next;

  logic          rx_pend;
  logic          tx_pend;
  logic          rx_fills;
  logic          tx_last;
  logic [W-1:0]  wr_word;

  sync_fifo_fwft #(
    .WIDTH      (W),
    .ADDR_WIDTH (RX_BUF_WIDTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data ({ft_be_i, ft_data_i}),
    .pop       (rx_ready),
    .head      (rx_head),
    .next_head (unused_rx_next),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  sync_fifo_fwft #(
    .WIDTH      (W),
    .ADDR_WIDTH (TX_BUF_WIDTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_valid),
    .push_data ({tx_be, tx_data}),
    .pop       (tx_pop),
    .head      (tx_head),
    .next_head (tx_next),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  assign {rx_be, rx_data} = rx_head;
  assign rx_valid = ~rx_empty;
  assign tx_ready = ~tx_full;
  assign rx_pop   = rx_valid & rx_ready;
  assign tx_push  = tx_valid & tx_ready;

  assign rx_pend  = ~ft_rxf_n & ~rx_full;
  assign tx_pend  = ~ft_txe_n & ~tx_empty;
  assign rx_fills = (rx_level == RX_ALMOST) & ~rx_pop;
  assign tx_last  = (tx_level == TX_ONE) & ~tx_push;

  assign cap     = (burst_cnt >= CNT_CAP);
  assign cnt_inc = (burst_cnt == CNT_MAX) ? burst_cnt
                                          : burst_cnt + 1'b1;

  assign {ft_be_o, ft_data_o} = wr_word;

  always_comb begin
    state_nx = state;
    dir_nx   = last_dir;
    cnt_nx   = burst_cnt;
    rx_push  = 1'b0;
    tx_pop   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (rx_pend && (!tx_pend || last_dir == DIR_WR)) begin
          state_nx = RD_OE;
          dir_nx   = DIR_RD;
        end else if (tx_pend) begin
          state_nx = WR_BURST;
          dir_nx   = DIR_WR;
        end
      end
      RD_OE: state_nx = RD_BURST;
      RD_BURST: begin
        if (ft_rxf_n) begin
          state_nx = RD_END;
        end else begin
          rx_push = 1'b1;
          cnt_nx  = cnt_inc;
          if (rx_fills || (cap && tx_pend)) state_nx = RD_END;
        end
      end
      RD_END: state_nx = IDLE;
      WR_BURST: begin
        if (ft_txe_n) begin
          state_nx = WR_END;
        end else begin
          tx_pop = 1'b1;
          cnt_nx = cnt_inc;
          if (tx_last || (cap && rx_pend)) state_nx = WR_END;
        end
      end
      WR_END: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_dir   <= DIR_WR;
      burst_cnt  <= '0;
      ft_oe_n    <= 1'b1;
      ft_rd_n    <= 1'b1;
      ft_wr_n    <= 1'b1;
      ft_data_oe <= 1'b0;
      wr_word    <= '0;
    end else begin
      state      <= state_nx;
      last_dir   <= dir_nx;
      burst_cnt  <= cnt_nx;
      ft_oe_n    <= ~(state_nx == RD_OE || state_nx == RD_BURST);
      ft_rd_n    <= (state_nx != RD_BURST);
      ft_wr_n    <= (state_nx != WR_BURST);
      ft_data_oe <= (state_nx == WR_BURST);
      if (state_nx == WR_BURST)
        wr_word <= (state == WR_BURST) ? tx_next : tx_head;
    end
  end

endmodule

// File: doc/ft60x_fifo_bridge.md
# ft60x_fifo_bridge

Parametrised synchronous 245-mode bridge between an FTDI FT600/FT601 (16/32-bit) and on-chip streaming logic. It buffers host→FPGA (RX) and FPGA→host (TX) words in internal FIFOs and arbitrates the half-duplex FT bus with a bounded burst length, so neither direction can starve the other. It sits between the top-level pad cells (SB_IO tristate, instantiated outside) and user logic, and replaces the fixed 16-bit FT600 interface. It supports 32-bit FT601, configurable FIFO depth, byte enables in both directions, and fair arbitration.

## Interface
- DATA_WIDTH, 16: FT bus width; 16 (FT600) or 32 (FT601).
- BE_WIDTH, DATA_WIDTH/8: byte-enable width; derived, not overridden.
- RX_BUF_WIDTH, 4: log2 RX FIFO depth.
- TX_BUF_WIDTH, 4: log2 TX FIFO depth.
- MAX_BURST, 16: maximum words per bus tenure while the other direction is pending; ≥1.

Ports:
- clk  in  1  FT60x CLKOUT (100 MHz); sole clock. Crossing into the system domain happens outside this block.
- rst_n  in  1  asynchronous, active-low reset.
- ft_data_i  in  DATA_WIDTH  pad input.
- ft_data_o  out  DATA_WIDTH  pad output.
- ft_data_oe  out  1  high = drive ft_data and ft_be.
- ft_be_i  in  BE_WIDTH  pad input.
- ft_be_o  out  BE_WIDTH  pad output.
- ft_txe_n  in  1  low = FT can accept a word.
- ft_rxf_n  in  1  low = FT has a word.
- ft_oe_n, ft_rd_n, ft_wr_n  out  1 each  active-low strobes.
- tx_data  in  DATA_WIDTH; tx_be  in  BE_WIDTH; tx_valid  in  1; tx_ready  out  1: TX push, transfer on valid&ready.
- rx_data  out  DATA_WIDTH; rx_be  out  BE_WIDTH; rx_valid  out  1; rx_ready  in  1: RX pop, first-word-fall-through.
- rx_level  out  RX_BUF_WIDTH+1; tx_level  out  TX_BUF_WIDTH+1: current occupancy.

## Operation
- FSM states: IDLE, RD_OE, RD_BURST, RD_END, WR_BURST, WR_END.
- rx_pend = !ft_rxf_n & rx FIFO not full. tx_pend = !ft_txe_n & TX FIFO not empty.
- IDLE: if only one direction is pending, take it. If both are pending, take the opposite of last_dir. last_dir resets to WR, so RX wins the first tie.
- RD_OE: ft_oe_n=0; go to RD_BURST.
- RD_BURST: ft_oe_n=0 and ft_rd_n=0. At each edge with !ft_rxf_n, push {ft_be_i, ft_data_i} into RX FIFO and increment burst_cnt.
  - Leave for RD_END at the same edge when: ft_rxf_n=1; or the push leaves the FIFO full; or burst_cnt reaches MAX_BURST while tx_pend.
- RD_END: all strobes high; go to IDLE.
- WR_BURST: ft_data_oe=1, ft_wr_n=0, ft_data_o/ft_be_o = TX FIFO head. At each edge with !ft_txe_n, pop and present the next head at that edge.
  - Leave for WR_END when: the pop empties the FIFO; or ft_txe_n=1; or burst_cnt reaches MAX_BURST while rx_pend.
- WR_END: ft_data_oe=0, strobes high; go to IDLE.
- A word is never lost or duplicated. Deasserting ft_txe_n holds the current head on the bus until it is accepted.
- Level counters: occupancy + push − pop, modulo depth+1 range; simultaneous push/pop leaves the count unchanged.
- tx_ready = TX not full. rx_valid = RX not empty.

## Timing
- Reset values: ft_oe_n=ft_rd_n=ft_wr_n=1, ft_data_oe=0, ft_data_o=0, ft_be_o=0, rx_valid=0, tx_ready=1, levels=0, state IDLE.
- Asserting reset mid-burst releases the bus immediately and flushes both FIFOs.
- All FT outputs are registered.
- Read: ft_oe_n falls at edge t, ft_rd_n falls at t+1, first sample at t+2.
- Write: ft_wr_n, ft_data_oe and the first word all change at the same edge.
- There is always ≥1 all-idle turnaround cycle between opposite-direction bursts.
- User-side latency: pushed TX word visible at FIFO head next cycle. RX word pushed at edge t gives rx_valid=1 after edge t.

## Structure
- Package ft60x_pkg: FSM state enum, direction enum, DIR_RD/DIR_WR constants.
- Sub-module sync_fifo_fwft (WIDTH, ADDR_WIDTH; level output), instantiated twice with WIDTH = DATA_WIDTH+BE_WIDTH.

## Test plan
- Reset: hold rst_n low 1 µs with random FT inputs → strobes 1, ft_data_oe 0, rx_valid 0, tx_ready 1.
- TX burst: push 0x0001, 0x0002, 0x0003, ft_txe_n=0 → ft_wr_n low exactly 3 cycles with the words in order, then WR_END, tx_level=0.
- TX backpressure: ft_txe_n rises after word 2 of 4 → word 3 held on ft_data_o. When ft_txe_n falls, words 3 and 4 are sent once each.
- RX fill: RX_BUF_WIDTH=4, rx_ready=0, ft_rxf_n held low, data 0x1000+n → exactly 16 words pushed, rx_level=16, ft_rd_n high after the 16th word.
- Arbitration: MAX_BURST=4, 12 TX words queued, ft_rxf_n and ft_txe_n both low → alternating 4-word RD/WR bursts, RX first, each separated by one idle cycle.
- FT601: DATA_WIDTH=32, tx_be=4'b0011 on the last word → ft_be_o=4'b0011 for that word only; rx_be mirrors ft_be_i.
